// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC generation, single-outstanding
// instruction-memory handshake, 2-entry {instruction, pc} buffer toward the
// decoder, and branch redirect with flush and stale-response drain.
// Optional feature: define IFETCH_PERF_CNT_EN to add transfer/redirect counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2  // only 2 is supported
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        br_valid,
  input  logic        Uncondbranch,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] br_pc,
  input  logic [31:0] Sign_extend
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam logic [1:0] FULL = BUF_DEPTH[1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] fetch_pc;
  logic [31:0] drain_addr;
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        redirect;
  logic        redir_act;
  logic [31:0] target;
  logic        accept;
  logic        xfer;
  logic        wr_en;
  logic        rd_en;

  // Branch target: word offset scaled to bytes, wrapping modulo 2^32, aligned.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [31:0] offset);
    logic signed [31:0] off_s;
    logic signed [31:0] sum;
    off_s = $signed(offset);
    sum   = $signed(pc) + (off_s <<< 2);
    return $unsigned(sum) & 32'hFFFF_FFFC;
  endfunction

  // Handshake decode; a redirect pre-empts any same-cycle buffer write or read.
  always_comb begin
    redirect   = br_valid & (Uncondbranch | (Branch & Zero));
    redir_act  = redirect & (state != IDLE);
    target     = branch_target(br_pc, Sign_extend);
    imem_req   = (state == DRAIN) || ((state == FETCH) && (count != FULL));
    imem_addr  = (state == DRAIN) ? drain_addr : fetch_pc;
    accept     = imem_req & imem_ack;
    inst_valid = (count != 2'd0);
    xfer       = inst_valid & inst_ready;
    wr_en      = accept & (state == FETCH) & ~redir_act;
    rd_en      = xfer & ~redir_act;
    Instruction = buf_inst[rd_ptr];
    inst_pc     = buf_pc[rd_ptr];
  end

  // Next-state logic; redirect overrides the normal transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (wr_en && !rd_en && (count == FULL - 2'd1)) state_nxt = HOLD;
      HOLD:  if (rd_en) state_nxt = FETCH;
      DRAIN: if (accept) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (redir_act) begin
      state_nxt = (imem_req && !imem_ack) ? DRAIN : FETCH;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Fetch PC: jumps to the target on redirect, otherwise steps on each accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redir_act) begin
      fetch_pc <= target;
    end else if (wr_en) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Capture the address of the abandoned request so it stays on the bus while draining.
  always_ff @(posedge clk) begin
    if (redir_act && (state != DRAIN) && imem_req && !imem_ack) begin
      drain_addr <= fetch_pc;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redir_act) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; cleared on reset so the decoder sees zeros out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_inst[0] <= 32'd0;
      buf_inst[1] <= 32'd0;
      buf_pc[0]   <= 32'd0;
      buf_pc[1]   <= 32'd0;
    end else if (wr_en) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Performance counters: decoder transfers and taken redirects, free-running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= 32'd0;
      perf_redirect_cnt <= 32'd0;
    end else begin
      if (xfer)      perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redir_act) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations followed by randomized traffic, all against a queue-based model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_valid;
  logic        Uncondbranch;
  logic        Branch;
  logic        Zero;
  logic [31:0] br_pc;
  logic [31:0] Sign_extend;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .br_valid(br_valid), .Uncondbranch(Uncondbranch), .Branch(Branch), .Zero(Zero),
    .br_pc(br_pc), .Sign_extend(Sign_extend)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Behavioural model: buffered words, fetch PC, drain bookkeeping.
  ent_t        q[$];
  bit          m_idle;
  bit          m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  logic [31:0] m_pf;
  logic [31:0] m_pr;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit exp_req();
    return !m_idle && (m_drain || (q.size() < 2));
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drain ? m_daddr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every meaningful DUT output against the model.
  task automatic compare();
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
    if (exp_req() || m_idle) chk("imem_addr", imem_addr, exp_addr());
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("Instruction", Instruction, q[0].inst);
      chk("inst_pc", inst_pc, q[0].pc);
    end
    if (m_idle) begin
      chk("Instruction_rst", Instruction, 32'd0);
      chk("inst_pc_rst", inst_pc, 32'd0);
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_pf);
    chk("perf_redirect_cnt", perf_redirect_cnt, m_pr);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit a_rst, input bit a_ack, input bit a_rdy,
                      input bit a_bv, input bit a_u, input bit a_b, input bit a_z,
                      input logic [31:0] a_brpc, input logic [31:0] a_se);
    bit          req_now;
    bit          ack_eff;
    bit          redir;
    bit          xf;
    logic [31:0] tgt;
    req_now = exp_req();
    ack_eff = (m_idle || !a_rst) ? a_ack : (a_ack & req_now);
    rst_n        = a_rst;
    imem_ack     = ack_eff;
    imem_rdata   = mem_word(exp_addr());
    inst_ready   = a_rdy;
    br_valid     = a_bv;
    Uncondbranch = a_u;
    Branch       = a_b;
    Zero         = a_z;
    br_pc        = a_brpc;
    Sign_extend  = a_se;

    redir = a_bv & (a_u | (a_b & a_z));
    tgt   = (a_brpc + (a_se << 2)) & 32'hFFFF_FFFC;
    xf    = (q.size() > 0) && a_rdy;
    if (!a_rst) begin
      q.delete();
      m_idle = 1; m_drain = 0; m_pc = 32'h0; m_pf = 0; m_pr = 0;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (redir) begin
      q.delete();
      if (req_now && !ack_eff) begin
        if (!m_drain) m_daddr = exp_addr();
        m_drain = 1;
      end else begin
        m_drain = 0;
      end
      m_pc = tgt;
      m_pr++;
      if (xf) m_pf++;
    end else begin
      if (xf) begin
        void'(q.pop_front());
        m_pf++;
      end
      if (req_now && ack_eff) begin
        if (m_drain) m_drain = 0;
        else begin
          q.push_back('{inst: mem_word(m_pc), pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic plain(input bit a_ack, input bit a_rdy);
    step(1, a_ack, a_rdy, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 0; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
    br_valid = 0; Uncondbranch = 0; Branch = 0; Zero = 0; br_pc = 0; Sign_extend = 0;
    m_idle = 1; m_drain = 0; m_pc = 0; m_daddr = 0; m_pf = 0; m_pr = 0;
    @(negedge clk);

    // Reset, including an ack from an abandoned transaction.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", Instruction, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // Streaming: addresses 0,4,8,12 with inst_pc one cycle behind.
    plain(1, 1);
    chk("seq_addr0", imem_addr, 32'h0);
    chk("seq_req0", {31'd0, imem_req}, 32'd1);
    plain(1, 1);
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_pc0", inst_pc, 32'h0);
    plain(1, 1);
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_pc4", inst_pc, 32'h4);
    plain(1, 1);
    chk("seq_addr12", imem_addr, 32'hC);
    chk("seq_pc8", inst_pc, 32'h8);

    // Decoder stalls: buffer fills, requests stop, head stays put.
    for (int i = 0; i < 6; i++) plain(1, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_pc", inst_pc, 32'h8);
    chk("hold_inst", Instruction, mem_word(32'h8));
    plain(1, 1);
    chk("drain_pc12", inst_pc, 32'hC);
    plain(0, 1);

    // Taken conditional branch from a full buffer with nothing outstanding.
    for (int i = 0; i < 3; i++) plain(1, 0);
    step(1, 0, 0, 1, 0, 1, 1, 32'h40, 32'hFFFF_FFFE);
    chk("br_addr", imem_addr, 32'h38);
    chk("br_flush", {31'd0, inst_valid}, 32'd0);

    // Redirect while a request waits: drain the stale response.
    step(1, 1, 1, 1, 1, 0, 0, 32'h20, 32'h0);
    chk("to20_addr", imem_addr, 32'h20);
    step(1, 0, 1, 1, 1, 0, 0, 32'hF0, 32'h4);
    chk("drain_addr", imem_addr, 32'h20);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    plain(0, 1);
    plain(0, 1);
    plain(1, 1);
    chk("post_drain_addr", imem_addr, 32'h100);
    chk("post_drain_valid", {31'd0, inst_valid}, 32'd0);
    plain(1, 0);
    chk("tgt_pc", inst_pc, 32'h100);

    // Non-taken resolution is ignored.
    step(1, 0, 0, 1, 0, 1, 0, 32'h500, 32'h10);
    chk("nt_pc", inst_pc, 32'h100);

    // PC wrap at the top of the address space.
    step(1, 1, 1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    plain(1, 1);
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit          r_rst;
      bit          r_bv;
      logic [31:0] r_se;
      r_rst = ($urandom_range(0, 249) != 0);
      r_bv  = ($urandom_range(0, 7) == 0);
      r_se  = $urandom_range(0, 1) ? $urandom_range(0, 64) : (32'd0 - $urandom_range(0, 64));
      step(r_rst, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
           r_bv, ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom & 32'hFFFF_FFFC, r_se);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
